cache_controller: RTL and testbench

Sequencing controller for the N-way set-associative cache built around the tag-compare/hit datapath. It accepts single-word CPU requests and performs lookup in internal tag/data arrays, with hit = valid & tag match and lowest-index way priority. On a miss it writes back a dirty victim, refills the line from memory, and returns the response. It sits between the CPU load/store port and the memory bus, and owns all state of the cache arrays.

---
 rtl/cache_controller_if.sv | 39 +++
 rtl/cache_controller.sv | 187 ++++++++++++++++++
 tb/tb_cache_controller.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/cache_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : cache_controller_if
// Description : CPU request/response and memory bus bundle for the cache
//               controller. The slave modport is the controller side.
// Revision    : 1.0 - initial release
// ============================================================================
interface cache_controller_if #(
    parameter int TOTAL_WIDTH = 32
);
    logic                   req_valid_i;
    logic                   req_ready_o;
    logic                   req_we_i;
    logic [TOTAL_WIDTH-1:0] address_i;
    logic [TOTAL_WIDTH-1:0] wdata_i;
    logic                   rsp_valid_o;
    logic [TOTAL_WIDTH-1:0] rdata_o;
    logic                   mem_req_o;
    logic                   mem_we_o;
    logic [TOTAL_WIDTH-1:0] mem_addr_o;
    logic [TOTAL_WIDTH-1:0] mem_wdata_o;
    logic                   mem_ack_i;
    logic [TOTAL_WIDTH-1:0] mem_rdata_i;
    logic [31:0]            hit_count_o;
    logic [31:0]            miss_count_o;

    modport slave (
        input  req_valid_i, req_we_i, address_i, wdata_i, mem_ack_i, mem_rdata_i,
        output req_ready_o, rsp_valid_o, rdata_o, mem_req_o, mem_we_o,
               mem_addr_o, mem_wdata_o, hit_count_o, miss_count_o
    );

    modport master (
        output req_valid_i, req_we_i, address_i, wdata_i, mem_ack_i, mem_rdata_i,
        input  req_ready_o, rsp_valid_o, rdata_o, mem_req_o, mem_we_o,
               mem_addr_o, mem_wdata_o, hit_count_o, miss_count_o
    );
endinterface
`default_nettype wire

// File: rtl/cache_controller.sv
`default_nettype none
// ============================================================================
// Module      : cache_controller
// Description : Sequencer for an N-way set-associative write-back,
//               write-allocate cache with one-word lines. Owns tag/data
//               arrays, valid/dirty bits and per-set round-robin pointers.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_controller #(
    parameter int TAG_WIDTH    = 18,
    parameter int INDEX_WIDTH  = 10,
    parameter int OFFSET_WIDTH = 4,
    parameter int TOTAL_WIDTH  = 32,
    parameter int N            = 4
) (
    input  wire logic          clk_i,
    input  wire logic          rst_ni,
    cache_controller_if.slave  bus
);
    localparam int c_SETS  = 1 << INDEX_WIDTH;
    localparam int c_WAY_W = $clog2(N);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOOKUP    = 3'd1;
    localparam logic [2:0] S_WRITEBACK = 3'd2;
    localparam logic [2:0] S_REFILL    = 3'd3;
    localparam logic [2:0] S_RESPOND   = 3'd4;

    logic [2:0]             r_state;
    logic                   r_we;
    logic [TAG_WIDTH-1:0]   r_tag;
    logic [INDEX_WIDTH-1:0] r_index;
    logic [TOTAL_WIDTH-1:0] r_wdata;
    logic [c_WAY_W-1:0]     r_victim;
    logic [TOTAL_WIDTH-1:0] r_rdata;
    logic [TOTAL_WIDTH-1:0] r_mem_addr;
    logic [TOTAL_WIDTH-1:0] r_mem_wdata;
    logic [31:0]            r_hit_count;
    logic [31:0]            r_miss_count;

    logic [c_SETS-1:0][N-1:0]       r_valid;
    logic [c_SETS-1:0][N-1:0]       r_dirty;
    logic [c_SETS-1:0][c_WAY_W-1:0] r_ptr;
    logic [TAG_WIDTH-1:0]           r_tag_mem  [c_SETS][N];
    logic [TOTAL_WIDTH-1:0]         r_data_mem [c_SETS][N];

    logic [N-1:0]       w_hit;
    logic               w_hit_any;
    logic [c_WAY_W-1:0] w_hit_way;
    logic               w_inv_any;
    logic [c_WAY_W-1:0] w_inv_way;
    logic [c_WAY_W-1:0] w_victim;
    logic               w_refill_done;
    logic               w_write_hit;
    logic               w_unused_offset;

    // Byte offset never takes part in lookup.
    assign w_unused_offset = ^bus.address_i[OFFSET_WIDTH-1:0];

    assign w_refill_done = (r_state == S_REFILL) && bus.mem_ack_i;
    assign w_write_hit   = (r_state == S_LOOKUP) && w_hit_any && r_we;

    // Hit vector, lowest-index hit/invalid way encoders and victim choice.
    always_comb begin
        w_hit     = '0;
        w_hit_any = 1'b0;
        w_hit_way = '0;
        w_inv_any = 1'b0;
        w_inv_way = '0;
        for (int w = 0; w < N; w++) begin
            w_hit[w] = r_valid[r_index][w] && (r_tag_mem[r_index][w] == r_tag);
        end
        for (int w = N - 1; w >= 0; w--) begin
            if (w_hit[w]) begin
                w_hit_any = 1'b1;
                w_hit_way = c_WAY_W'(w);
            end
            if (!r_valid[r_index][w]) begin
                w_inv_any = 1'b1;
                w_inv_way = c_WAY_W'(w);
            end
        end
        w_victim = w_inv_any ? w_inv_way : r_ptr[r_index];
    end

    // Control FSM, request latch, output registers and statistics.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_tag        <= '0;
            r_index      <= '0;
            r_wdata      <= '0;
            r_victim     <= '0;
            r_rdata      <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid_i) begin
                        r_we    <= bus.req_we_i;
                        r_tag   <= bus.address_i[TOTAL_WIDTH-1 -: TAG_WIDTH];
                        r_index <= bus.address_i[OFFSET_WIDTH +: INDEX_WIDTH];
                        r_wdata <= bus.wdata_i;
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit_any) begin
                        if (r_hit_count != 32'hFFFF_FFFF) r_hit_count <= r_hit_count + 32'd1;
                        r_rdata <= r_we ? r_wdata : r_data_mem[r_index][w_hit_way];
                        r_state <= S_RESPOND;
                    end else begin
                        if (r_miss_count != 32'hFFFF_FFFF) r_miss_count <= r_miss_count + 32'd1;
                        r_victim <= w_victim;
                        if (r_valid[r_index][w_victim] && r_dirty[r_index][w_victim]) begin
                            r_mem_addr  <= {r_tag_mem[r_index][w_victim], r_index, {OFFSET_WIDTH{1'b0}}};
                            r_mem_wdata <= r_data_mem[r_index][w_victim];
                            r_state     <= S_WRITEBACK;
                        end else begin
                            r_mem_addr <= {r_tag, r_index, {OFFSET_WIDTH{1'b0}}};
                            r_state    <= S_REFILL;
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (bus.mem_ack_i) begin
                        r_mem_addr <= {r_tag, r_index, {OFFSET_WIDTH{1'b0}}};
                        r_state    <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (bus.mem_ack_i) begin
                        r_rdata <= r_we ? r_wdata : bus.mem_rdata_i;
                        r_state <= S_RESPOND;
                    end
                end
                S_RESPOND: r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    // Line metadata: valid, dirty and round-robin pointer per set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= '0;
            r_dirty <= '0;
            r_ptr   <= '0;
        end else begin
            if (w_write_hit) begin
                r_dirty[r_index][w_hit_way] <= 1'b1;
            end
            if (w_refill_done) begin
                r_valid[r_index][r_victim] <= 1'b1;
                r_dirty[r_index][r_victim] <= r_we;
                r_ptr[r_index]             <= r_ptr[r_index] + 1'b1;
            end
        end
    end

    // Tag and data storage, not reset; qualified by the valid bits.
    always_ff @(posedge clk_i) begin
        if (w_write_hit) begin
            r_data_mem[r_index][w_hit_way] <= r_wdata;
        end
        if (w_refill_done) begin
            r_tag_mem[r_index][r_victim]  <= r_tag;
            r_data_mem[r_index][r_victim] <= r_we ? r_wdata : bus.mem_rdata_i;
        end
    end

    // Ready is held low while reset is asserted even though the FSM is IDLE.
    assign bus.req_ready_o  = rst_ni && (r_state == S_IDLE);
    assign bus.rsp_valid_o  = (r_state == S_RESPOND);
    assign bus.rdata_o      = r_rdata;
    assign bus.mem_req_o    = (r_state == S_WRITEBACK) || (r_state == S_REFILL);
    assign bus.mem_we_o     = (r_state == S_WRITEBACK);
    assign bus.mem_addr_o   = r_mem_addr;
    assign bus.mem_wdata_o  = r_mem_wdata;
    assign bus.hit_count_o  = r_hit_count;
    assign bus.miss_count_o = r_miss_count;
endmodule
`default_nettype wire

// File: tb/tb_cache_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_controller
// Description : Directed self-checking bench for cache_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_controller;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    cache_controller_if bus_if ();

    cache_controller dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request at a negedge; it is accepted at the following posedge.
    task automatic accept(input logic we, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        check("accept_ready", {31'd0, bus_if.req_ready_o}, 32'd1);
        bus_if.req_valid_i = 1'b1;
        bus_if.req_we_i    = we;
        bus_if.address_i   = addr;
        bus_if.wdata_i     = data;
        @(posedge clk);
        #1 bus_if.req_valid_i = 1'b0;
    endtask

    // Returns at a negedge where mem_req_o is high.
    task automatic wait_mem_req();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_if.mem_req_o && n < 50);
        if (!bus_if.mem_req_o) check("mem_req_timeout", 32'd0, 32'd1);
    endtask

    // Called at a negedge with mem_req_o high.
    task automatic ack(input logic [31:0] data);
        bus_if.mem_ack_i   = 1'b1;
        bus_if.mem_rdata_i = data;
        @(posedge clk);
        #1 bus_if.mem_ack_i = 1'b0;
    endtask

    task automatic wait_rsp(output int lat, output logic [31:0] data, output logic saw_mem);
        lat     = 0;
        saw_mem = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (bus_if.mem_req_o) saw_mem = 1'b1;
        end while (!bus_if.rsp_valid_o && lat < 50);
        if (!bus_if.rsp_valid_o) check("rsp_timeout", 32'd0, 32'd1);
        data = bus_if.rdata_o;
    endtask

    // Read miss to a clean/invalid victim: refill with fill_data.
    task automatic miss_read(input logic [31:0] addr, input logic [31:0] fill_data);
        int          lat;
        logic [31:0] d;
        logic        sm;
        accept(1'b0, addr, 32'd0);
        wait_mem_req();
        check("refill_addr", bus_if.mem_addr_o, addr);
        check("refill_we", {31'd0, bus_if.mem_we_o}, 32'd0);
        ack(fill_data);
        wait_rsp(lat, d, sm);
        check("refill_lat", lat, 32'd1);
        check("refill_rdata", d, fill_data);
    endtask

    task automatic hit_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] exp_data);
        int          lat;
        logic [31:0] d;
        logic        sm;
        accept(we, addr, wd);
        wait_rsp(lat, d, sm);
        check("hit_lat", lat, 32'd2);
        check("hit_rdata", d, exp_data);
        check("hit_no_mem", {31'd0, sm}, 32'd0);
    endtask

    initial begin
        int          lat;
        logic [31:0] d;
        logic        sm;
        n_checks = 0;
        n_fail   = 0;
        bus_if.req_valid_i = 1'b0;
        bus_if.req_we_i    = 1'b0;
        bus_if.address_i   = '0;
        bus_if.wdata_i     = '0;
        bus_if.mem_ack_i   = 1'b0;
        bus_if.mem_rdata_i = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, bus_if.req_ready_o}, 32'd0);
        check("rst_mem_req", {31'd0, bus_if.mem_req_o}, 32'd0);
        check("rst_rsp_valid", {31'd0, bus_if.rsp_valid_o}, 32'd0);
        check("rst_rdata", bus_if.rdata_o, 32'd0);
        check("rst_mem_addr", bus_if.mem_addr_o, 32'd0);
        check("rst_miss_cnt", bus_if.miss_count_o, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'd0, bus_if.req_ready_o}, 32'd1);

        // Cold read miss then hit on the same line.
        miss_read(32'h0000_1230, 32'hDEAD_BEEF);
        check("miss_cnt_1", bus_if.miss_count_o, 32'd1);
        hit_access(1'b0, 32'h0000_1230, 32'd0, 32'hDEAD_BEEF);
        check("hit_cnt_1", bus_if.hit_count_o, 32'd1);

        // Write hit makes way 0 dirty.
        hit_access(1'b1, 32'h0000_1230, 32'h1234_5678, 32'h1234_5678);
        check("hit_cnt_2", bus_if.hit_count_o, 32'd2);

        // Fill ways 1..3 of set 0x123; pointer wraps back to way 0.
        miss_read(32'h0000_5230, 32'h1111_0001);
        miss_read(32'h0000_9230, 32'h1111_0002);
        miss_read(32'h0000_D230, 32'h1111_0003);
        check("miss_cnt_4", bus_if.miss_count_o, 32'd4);

        // Conflict miss evicts dirty way 0.
        accept(1'b0, 32'h0001_1230, 32'd0);
        wait_mem_req();
        check("wb_we", {31'd0, bus_if.mem_we_o}, 32'd1);
        check("wb_addr", bus_if.mem_addr_o, 32'h0000_1230);
        check("wb_wdata", bus_if.mem_wdata_o, 32'h1234_5678);
        ack(32'h0);
        @(negedge clk);
        check("wb2rf_req", {31'd0, bus_if.mem_req_o}, 32'd1);
        check("wb2rf_we", {31'd0, bus_if.mem_we_o}, 32'd0);
        check("wb2rf_addr", bus_if.mem_addr_o, 32'h0001_1230);
        ack(32'hCAFE_F00D);
        wait_rsp(lat, d, sm);
        check("evict_lat", lat, 32'd1);
        check("evict_rdata", d, 32'hCAFE_F00D);
        hit_access(1'b0, 32'h0000_5230, 32'd0, 32'h1111_0001);

        // Write miss: allocate, fill data discarded.
        accept(1'b1, 32'h0000_2000, 32'hA5A5_A5A5);
        wait_mem_req();
        check("wmiss_we", {31'd0, bus_if.mem_we_o}, 32'd0);
        check("wmiss_addr", bus_if.mem_addr_o, 32'h0000_2000);
        ack(32'hFFFF_FFFF);
        wait_rsp(lat, d, sm);
        check("wmiss_rdata", d, 32'hA5A5_A5A5);
        hit_access(1'b0, 32'h0000_2000, 32'd0, 32'hA5A5_A5A5);
        check("miss_cnt_6", bus_if.miss_count_o, 32'd6);
        check("hit_cnt_4", bus_if.hit_count_o, 32'd4);

        // Slow memory: outputs hold, new requests ignored while busy.
        accept(1'b0, 32'h0000_3000, 32'd0);
        wait_mem_req();
        for (int i = 0; i < 5; i++) begin
            check("stall_req", {31'd0, bus_if.mem_req_o}, 32'd1);
            check("stall_addr", bus_if.mem_addr_o, 32'h0000_3000);
            check("stall_ready", {31'd0, bus_if.req_ready_o}, 32'd0);
            bus_if.req_valid_i = (i % 2 == 0);
            bus_if.address_i   = 32'h0000_1230;
            @(negedge clk);
        end
        bus_if.req_valid_i = 1'b0;
        check("stall_req_end", {31'd0, bus_if.mem_req_o}, 32'd1);
        ack(32'h3333_3333);
        wait_rsp(lat, d, sm);
        check("stall_rdata", d, 32'h3333_3333);
        @(negedge clk);
        check("stall_no_extra_rsp", {31'd0, bus_if.rsp_valid_o}, 32'd0);
        check("stall_idle_ready", {31'd0, bus_if.req_ready_o}, 32'd1);
        check("miss_cnt_7", bus_if.miss_count_o, 32'd7);
        check("hit_cnt_4b", bus_if.hit_count_o, 32'd4);

        // Reset in the middle of a refill.
        accept(1'b0, 32'h0000_7000, 32'd0);
        wait_mem_req();
        rst_n = 1'b0;
        #1;
        check("mid_rst_mem_req", {31'd0, bus_if.mem_req_o}, 32'd0);
        check("mid_rst_rsp", {31'd0, bus_if.rsp_valid_o}, 32'd0);
        check("mid_rst_miss_cnt", bus_if.miss_count_o, 32'd0);
        check("mid_rst_mem_addr", bus_if.mem_addr_o, 32'd0);
        repeat (2) @(negedge clk);
        check("mid_rst_no_rsp", {31'd0, bus_if.rsp_valid_o}, 32'd0);
        rst_n = 1'b1;
        miss_read(32'h0000_5230, 32'h5555_5555);
        check("post_rst_miss_cnt", bus_if.miss_count_o, 32'd1);
        check("post_rst_hit_cnt", bus_if.hit_count_o, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
